// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback arbiter.
//  - unit_code_e   : functional-unit codes carried in each packet
//  - field_e       : packet field selector
//  - field_lsb()   : LSB offset of a field inside a packed packet
//  - entry_w()     : packed packet width
//  - clog2()       : ceiling log2 usable in parameter expressions
// Packet layout, MSB first:
//   unitCode[3], wb1En, wb1Addr, wb1Val, wb2En, wb2Addr, wb2Val, crEn, crVal
package writeback_pkg;

  localparam int unsigned UnitCodeW = 3;

  typedef enum logic [UnitCodeW-1:0] {
    UnitFx     = 3'd0,
    UnitFp     = 3'd1,
    UnitLdst   = 3'd2,
    UnitBranch = 3'd3,
    UnitTrap   = 3'd4
  } unit_code_e;

  typedef enum int unsigned {
    FieldCrVal,
    FieldCrEn,
    FieldWb2Val,
    FieldWb2Addr,
    FieldWb2En,
    FieldWb1Val,
    FieldWb1Addr,
    FieldWb1En,
    FieldUnit
  } field_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int unsigned entry_w(input int unsigned rw, input int unsigned dw,
                                          input int unsigned cw);
    return UnitCodeW + 2 * (1 + rw + dw) + 1 + cw;
  endfunction

  function automatic int unsigned field_lsb(input field_e f, input int unsigned rw,
                                            input int unsigned dw, input int unsigned cw);
    int unsigned lsb;
    case (f)
      FieldCrVal:   lsb = 0;
      FieldCrEn:    lsb = cw;
      FieldWb2Val:  lsb = cw + 1;
      FieldWb2Addr: lsb = cw + 1 + dw;
      FieldWb2En:   lsb = cw + 1 + dw + rw;
      FieldWb1Val:  lsb = cw + 2 + dw + rw;
      FieldWb1Addr: lsb = cw + 2 + 2 * dw + rw;
      FieldWb1En:   lsb = cw + 2 + 2 * dw + 2 * rw;
      FieldUnit:    lsb = cw + 3 + 2 * dw + 2 * rw;
      default:      lsb = 0;
    endcase
    return lsb;
  endfunction

endpackage

// File: rtl/wb_channel_fifo.sv
// Per-channel packet FIFO.
//  clock_i, reset_i (async, active-low), flush_i (sync clear)
//  push/din : write when not full
//  pop/dout : dout is the current head; pop advances it when not empty
//  empty/full : registered-state status flags
module wb_channel_fifo
  import writeback_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 176
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = clog2(FIFO_DEPTH);
  localparam int unsigned CntW = clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush_i;
  assign do_pop  = pop && !empty && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin merge of NUM_UNITS writeback channels into one registered writeback port.
//  Inputs : clock_i, reset_i (async, active-low), flush_i, unitValid_i, unitPacket_i,
//           wbReady_i
//  Outputs: unitReady_o (per-channel space), wbValid_o, grantChannel_o and the unpacked
//           fields of the granted packet.
// A packet arriving on a channel whose FIFO is empty may be loaded straight into the
// output register at the same edge, giving one-cycle latency without a combinational
// input-to-output path.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int unsigned NUM_UNITS  = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned REG_WIDTH  = 5,
  parameter int unsigned CR_WIDTH   = 32,
  parameter int unsigned ENTRY_W    = entry_w(REG_WIDTH, DATA_WIDTH, CR_WIDTH)
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic [NUM_UNITS-1:0]           unitValid_i,
  output logic [NUM_UNITS-1:0]           unitReady_o,
  input  logic [NUM_UNITS*ENTRY_W-1:0]   unitPacket_i,
  input  logic                           wbReady_i,
  output logic                           wbValid_o,
  output logic [clog2(NUM_UNITS)-1:0]    grantChannel_o,
  output logic [UnitCodeW-1:0]           functionalUnitCode_o,
  output logic                           reg1WritebackEnable_o,
  output logic [REG_WIDTH-1:0]           reg1WritebackAddress_o,
  output logic [DATA_WIDTH-1:0]          reg1WritebackVal_o,
  output logic                           reg2WritebackEnable_o,
  output logic [REG_WIDTH-1:0]           reg2WritebackAddress_o,
  output logic [DATA_WIDTH-1:0]          reg2WritebackVal_o,
  output logic                           condRegUpdateEnable_o,
  output logic [CR_WIDTH-1:0]            newCRVal_o
);

  localparam int unsigned GrantW   = clog2(NUM_UNITS);
  localparam int unsigned CrValLsb = field_lsb(FieldCrVal,   REG_WIDTH, DATA_WIDTH, CR_WIDTH);
  localparam int unsigned CrEnBit  = field_lsb(FieldCrEn,    REG_WIDTH, DATA_WIDTH, CR_WIDTH);
  localparam int unsigned Wb2ValLsb = field_lsb(FieldWb2Val, REG_WIDTH, DATA_WIDTH, CR_WIDTH);
  localparam int unsigned Wb2AdrLsb = field_lsb(FieldWb2Addr, REG_WIDTH, DATA_WIDTH, CR_WIDTH);
  localparam int unsigned Wb2EnBit = field_lsb(FieldWb2En,   REG_WIDTH, DATA_WIDTH, CR_WIDTH);
  localparam int unsigned Wb1ValLsb = field_lsb(FieldWb1Val, REG_WIDTH, DATA_WIDTH, CR_WIDTH);
  localparam int unsigned Wb1AdrLsb = field_lsb(FieldWb1Addr, REG_WIDTH, DATA_WIDTH, CR_WIDTH);
  localparam int unsigned Wb1EnBit = field_lsb(FieldWb1En,   REG_WIDTH, DATA_WIDTH, CR_WIDTH);
  localparam int unsigned UnitLsb  = field_lsb(FieldUnit,    REG_WIDTH, DATA_WIDTH, CR_WIDTH);

  logic [ENTRY_W-1:0]   pkt_in    [NUM_UNITS];
  logic [ENTRY_W-1:0]   fifo_head [NUM_UNITS];
  logic [NUM_UNITS-1:0] fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [NUM_UNITS-1:0] keep, cand;

  logic [ENTRY_W-1:0]   out_q, out_d;
  logic [GrantW-1:0]    grant_q, grant_d, rr_q, rr_d;
  logic                 valid_q, valid_d;
  logic [GrantW-1:0]    grant_idx, cand_idx;
  logic                 grant_found, take;

  for (genvar c = 0; c < NUM_UNITS; c++) begin : g_chan
    assign pkt_in[c] = unitPacket_i[c*ENTRY_W +: ENTRY_W];
    // Packets with no enable complete the handshake but are never stored.
    assign keep[c] = unitValid_i[c] && !fifo_full[c] &&
                     (pkt_in[c][Wb1EnBit] || pkt_in[c][Wb2EnBit] || pkt_in[c][CrEnBit]);
    assign cand[c] = !fifo_empty[c] || keep[c];

    wb_channel_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (ENTRY_W)
    ) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .push    (fifo_push[c]),
      .pop     (fifo_pop[c]),
      .din     (pkt_in[c]),
      .dout    (fifo_head[c]),
      .empty   (fifo_empty[c]),
      .full    (fifo_full[c])
    );
  end

  assign unitReady_o = ~fifo_full;

  // Round-robin search starting at rr_q.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      cand_idx = GrantW'((32'(rr_q) + i) % NUM_UNITS);
      if (!grant_found && cand[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    out_d     = out_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    rr_d      = rr_q;
    fifo_pop  = '0;
    fifo_push = keep;
    take      = !flush_i && (!valid_q || wbReady_i) && grant_found;

    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!valid_q || wbReady_i) begin
      valid_d = grant_found;
      if (grant_found) begin
        // Empty FIFO: the incoming packet is its head and bypasses storage.
        out_d   = fifo_empty[grant_idx] ? pkt_in[grant_idx] : fifo_head[grant_idx];
        grant_d = grant_idx;
        rr_d    = (grant_idx == GrantW'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end

    for (int unsigned c = 0; c < NUM_UNITS; c++) begin
      if (take && grant_idx == GrantW'(c)) begin
        if (fifo_empty[c]) fifo_push[c] = 1'b0;
        else               fifo_pop[c]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      out_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      rr_q    <= '0;
    end else begin
      out_q   <= out_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  assign wbValid_o              = valid_q;
  assign grantChannel_o         = grant_q;
  assign functionalUnitCode_o   = out_q[UnitLsb +: UnitCodeW];
  assign reg1WritebackEnable_o  = out_q[Wb1EnBit];
  assign reg1WritebackAddress_o = out_q[Wb1AdrLsb +: REG_WIDTH];
  assign reg1WritebackVal_o     = out_q[Wb1ValLsb +: DATA_WIDTH];
  assign reg2WritebackEnable_o  = out_q[Wb2EnBit];
  assign reg2WritebackAddress_o = out_q[Wb2AdrLsb +: REG_WIDTH];
  assign reg2WritebackVal_o     = out_q[Wb2ValLsb +: DATA_WIDTH];
  assign condRegUpdateEnable_o  = out_q[CrEnBit];
  assign newCRVal_o             = out_q[CrValLsb +: CR_WIDTH];

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int NU = 3;
  localparam int D  = 4;
  localparam int EW = 176;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [NU-1:0] uvalid = '0;
  logic [NU-1:0] uready;
  logic [NU*EW-1:0] upkt = '0;
  logic          wbready = 1'b0;
  logic          wbvalid;
  logic [1:0]    grant;
  logic [2:0]    fuc;
  logic          r1en, r2en, cren;
  logic [4:0]    r1a, r2a;
  logic [63:0]   r1v, r2v;
  logic [31:0]   crv;
  logic [EW-1:0] dut_pkt;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus the output slot.
  logic [EW-1:0] mq [NU][$];
  bit            m_valid;
  logic [EW-1:0] m_pkt;
  int            m_grant;
  int            m_rr;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .NUM_UNITS  (3),
    .FIFO_DEPTH (4),
    .DATA_WIDTH (64),
    .REG_WIDTH  (5),
    .CR_WIDTH   (32),
    .ENTRY_W    (176)
  ) dut (
    .clock_i                (clk),
    .reset_i                (rst_n),
    .flush_i                (flush),
    .unitValid_i            (uvalid),
    .unitReady_o            (uready),
    .unitPacket_i           (upkt),
    .wbReady_i              (wbready),
    .wbValid_o              (wbvalid),
    .grantChannel_o         (grant),
    .functionalUnitCode_o   (fuc),
    .reg1WritebackEnable_o  (r1en),
    .reg1WritebackAddress_o (r1a),
    .reg1WritebackVal_o     (r1v),
    .reg2WritebackEnable_o  (r2en),
    .reg2WritebackAddress_o (r2a),
    .reg2WritebackVal_o     (r2v),
    .condRegUpdateEnable_o  (cren),
    .newCRVal_o             (crv)
  );

  assign dut_pkt = {fuc, r1en, r1a, r1v, r2en, r2a, r2v, cren, crv};

  function automatic logic [EW-1:0] mk(logic [2:0] u, bit e1, logic [4:0] a1, logic [63:0] v1,
                                       bit e2, logic [4:0] a2, logic [63:0] v2,
                                       bit ce, logic [31:0] cv);
    return {u, e1, a1, v1, e2, a2, v2, ce, cv};
  endfunction

  function automatic bit has_en(logic [EW-1:0] p);
    return p[172] | p[102] | p[32];
  endfunction

  function automatic logic [EW-1:0] rnd_pkt(bit allow_empty);
    bit e1, e2, ce;
    e1 = 1'($urandom);
    e2 = 1'($urandom);
    ce = 1'($urandom);
    if (!allow_empty && !(e1 || e2 || ce)) e1 = 1'b1;
    return mk(3'($urandom_range(0, 4)), e1, 5'($urandom), {$urandom, $urandom},
              e2, 5'($urandom), {$urandom, $urandom}, ce, $urandom);
  endfunction

  task automatic set_pkt(int c, logic [EW-1:0] p);
    upkt[c*EW +: EW] = p;
  endtask

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NU; c++) mq[c].delete();
    m_valid = 1'b0;
    m_pkt   = '0;
    m_grant = 0;
    m_rr    = 0;
  endtask

  task automatic compare_all();
    logic [NU-1:0] er;
    for (int c = 0; c < NU; c++) er[c] = (mq[c].size() != D);
    check("wbValid", 256'(wbvalid), 256'(m_valid));
    check("unitReady", 256'(uready), 256'(er));
    if (m_valid) begin
      check("grant", 256'(grant), 256'(m_grant));
      check("packet", 256'(dut_pkt), 256'(m_pkt));
    end
  endtask

  // One clock: advance the model from the current inputs, then compare after the edge.
  task automatic step();
    bit ok [NU];
    for (int c = 0; c < NU; c++) ok[c] = uvalid[c] && (mq[c].size() != D);
    if (flush) begin
      for (int c = 0; c < NU; c++) mq[c].delete();
      m_valid = 1'b0;
    end else begin
      for (int c = 0; c < NU; c++)
        if (ok[c] && has_en(upkt[c*EW +: EW])) mq[c].push_back(upkt[c*EW +: EW]);
      if (!m_valid || wbready) begin
        int g;
        g = -1;
        for (int i = 0; i < NU; i++) begin
          int c;
          c = (m_rr + i) % NU;
          if (g < 0 && mq[c].size() > 0) g = c;
        end
        if (g >= 0) begin
          m_pkt   = mq[g].pop_front();
          m_valid = 1'b1;
          m_grant = g;
          m_rr    = (g + 1) % NU;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic async_reset(string tag);
    #2;
    rst_n   = 1'b0;
    uvalid  = '0;
    flush   = 1'b0;
    wbready = 1'b0;
    #1;
    check({tag, "_valid"}, 256'(wbvalid), 256'(0));
    check({tag, "_ready"}, 256'(uready), 256'(3'b111));
    check({tag, "_data"}, 256'(dut_pkt), 256'(0));
    check({tag, "_grant"}, 256'(grant), 256'(0));
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check("rst_valid", 256'(wbvalid), 256'(0));
    check("rst_ready", 256'(uready), 256'(3'b111));
    check("rst_data", 256'(dut_pkt), 256'(0));
    check("rst_grant", 256'(grant), 256'(0));
    #9;
    rst_n = 1'b1;

    // Single FX packet: visible one cycle after the push.
    set_pkt(0, mk(3'd0, 1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b0, 32'd0));
    uvalid  = 3'b001;
    wbready = 1'b1;
    step();
    check("t1_valid", 256'(wbvalid), 256'(1));
    check("t1_addr", 256'(r1a), 256'(5));
    check("t1_val", 256'(r1v), 256'(64'hDEAD));
    check("t1_grant", 256'(grant), 256'(0));
    uvalid = '0;
    step();

    // Round-robin order 0,1,2 then a fresh channel-0 packet after channel 2.
    async_reset("rst2");
    wbready = 1'b1;
    for (int c = 0; c < NU; c++) set_pkt(c, rnd_pkt(1'b0));
    uvalid = 3'b111;
    step();
    check("rr_first", 256'(grant), 256'(0));
    set_pkt(0, rnd_pkt(1'b0));
    uvalid = 3'b001;
    step();
    check("rr_second", 256'(grant), 256'(1));
    uvalid = '0;
    step();
    check("rr_third", 256'(grant), 256'(2));
    step();
    check("rr_fourth", 256'(grant), 256'(0));
    step();

    // Backpressure: five packets on channel 1 with the writeback stage stalled.
    wbready = 1'b0;
    uvalid  = 3'b010;
    for (int i = 0; i < 5; i++) begin
      set_pkt(1, rnd_pkt(1'b0));
      step();
    end
    check("bp_ready", 256'(uready), 256'(3'b101));
    uvalid = '0;
    for (int i = 0; i < 3; i++) step();
    check("bp_hold_valid", 256'(wbvalid), 256'(1));
    wbready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("bp_drained", 256'(wbvalid), 256'(0));

    // Packets with no enables are dropped.
    for (int c = 0; c < NU; c++)
      set_pkt(c, mk(3'($urandom_range(0, 4)), 1'b0, 5'd3, 64'd7, 1'b0, 5'd4, 64'd8, 1'b0, 32'd9));
    uvalid = 3'b111;
    step();
    step();
    uvalid = '0;
    step();
    check("noen_valid", 256'(wbvalid), 256'(0));
    check("noen_ready", 256'(uready), 256'(3'b111));

    // Flush with channels 0 and 2 loaded and a simultaneous push on channel 1.
    wbready = 1'b0;
    uvalid  = 3'b101;
    for (int i = 0; i < 3; i++) begin
      set_pkt(0, rnd_pkt(1'b0));
      set_pkt(2, rnd_pkt(1'b0));
      step();
    end
    set_pkt(1, rnd_pkt(1'b0));
    uvalid = 3'b010;
    flush  = 1'b1;
    step();
    check("flush_valid", 256'(wbvalid), 256'(0));
    check("flush_ready", 256'(uready), 256'(3'b111));
    flush   = 1'b0;
    uvalid  = '0;
    wbready = 1'b1;
    step();
    check("flush_empty", 256'(wbvalid), 256'(0));

    // Asynchronous reset mid-drain, then normal one-cycle latency.
    wbready = 1'b0;
    uvalid  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < NU; c++) set_pkt(c, rnd_pkt(1'b0));
      step();
    end
    uvalid  = '0;
    wbready = 1'b1;
    step();
    async_reset("rst_mid");
    set_pkt(2, rnd_pkt(1'b0));
    uvalid  = 3'b100;
    wbready = 1'b1;
    step();
    check("post_rst_valid", 256'(wbvalid), 256'(1));
    check("post_rst_grant", 256'(grant), 256'(2));
    uvalid = '0;
    step();

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NU; c++) set_pkt(c, rnd_pkt($urandom_range(0, 7) == 0));
      uvalid  = 3'($urandom);
      wbready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 39) == 0);
      step();
    end
    flush   = 1'b0;
    uvalid  = '0;
    wbready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    check("final_idle", 256'(wbvalid), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
